alu_seq_ctrl: RTL and testbench

Multi-cycle program sequencer for the accumulator-style ALU. It owns the program counter and fetches 9-bit instructions from a registered instruction ROM. It decodes each instruction into the ALU fields (OP, T, ImmI, ImmX) and register-file read/write controls, and updates the PC using the ALU's branch offset/sign. It sits between the top-level Start/Ack handshake and the datapath (ALU plus 16-entry register file; r0 is the accumulator).

---
 rtl/alu_seq_ctrl_if.sv | 43 ++++
 rtl/alu_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl_if
//  Description : Bundle between the ALU program sequencer and its environment.
//                Carries the Start/Ack handshake, the instruction-ROM port, the
//                decoded ALU fields and register-file controls, the ALU
//                branch feedback, and the run statistics.
//                master = sequencer side, slave = environment/datapath side.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_seq_ctrl_if #(
   parameter int PC_W = 8
);
   logic            Start;        // level run request
   logic            Ack;          // program finished, held until Start drops
   logic [PC_W-1:0] imem_addr;    // instruction ROM address (= PC)
   logic [8:0]      imem_data;    // ROM data, one cycle after imem_addr
   logic [3:0]      alu_op;       // IR[8:5]
   logic            alu_t;        // IR[4]
   logic [4:0]      alu_immi;     // IR[4:0]
   logic [3:0]      alu_immx;     // IR[3:0]
   logic [3:0]      rf_raddr;     // rs select, IR[3:0]
   logic            rf_we;        // register write enable
   logic [3:0]      rf_waddr;     // write destination
   logic [7:0]      alu_out;      // ALU result (datapath-routed)
   logic [3:0]      alu_boffset;  // branch offset magnitude
   logic            alu_bsign;    // branch direction, 1 = backward
   logic [15:0]     instr_count;  // retired instructions, saturating
   logic            timeout;      // run ended by watchdog

   modport master (
      input  Start, imem_data, alu_out, alu_boffset, alu_bsign,
      output Ack, imem_addr, alu_op, alu_t, alu_immi, alu_immx,
             rf_raddr, rf_we, rf_waddr, instr_count, timeout
   );

   modport slave (
      output Start, imem_data, alu_out, alu_boffset, alu_bsign,
      input  Ack, imem_addr, alu_op, alu_t, alu_immi, alu_immx,
             rf_raddr, rf_we, rf_waddr, instr_count, timeout
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Multi-cycle program sequencer for the accumulator ALU.
//                Fetches 9-bit instructions from a registered ROM, decodes
//                them into ALU fields and register-file controls, and updates
//                the PC from the ALU branch feedback. Each instruction takes
//                FETCH -> DECODE -> EXEC (3 cycles). A halt word or the
//                retired-instruction watchdog ends the run in DONE (Ack=1).
//  Ports       : CLK, Reset (sync, active-high)
//                bus (alu_seq_ctrl_if.master): Start/Ack handshake, imem port,
//                ALU fields, rf_raddr/rf_we/rf_waddr, ALU branch inputs,
//                instr_count and timeout status.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_ctrl #(
   parameter int         PC_W      = 8,
   parameter int         MAX_INSTR = 4096,
   parameter logic [8:0] HALT_WORD = 9'h1FF
) (
   input  wire logic        CLK,
   input  wire logic        Reset,
   alu_seq_ctrl_if.master   bus
);

   // Opcode mnemonics used by the controller (shared ALU opcode map)
   localparam logic [3:0]  kLRS          = 4'h8;
   localparam logic [3:0]  kGST          = 4'h9;
   localparam logic [3:0]  kBRC          = 4'hC;
   localparam logic [15:0] c_max_instr   = 16'(MAX_INSTR);
   localparam logic [15:0] c_count_sat   = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_nxt;
   logic [8:0]      r_ir;
   logic [8:0]      w_ir_nxt;
   logic [15:0]     r_count;
   logic [15:0]     w_count_nxt;
   logic [15:0]     w_count_inc;
   logic            r_timeout;
   logic            w_timeout_nxt;
   logic [3:0]      w_op;
   logic            w_exec;
   logic            w_we;
   logic            w_unused_alu_out;

   // ALU result is routed by the datapath; the sequencer does not consume it
   assign w_unused_alu_out = ^bus.alu_out;

   assign w_op        = r_ir[8:5];
   assign w_exec      = (r_state == S_EXEC);
   assign w_count_inc = (r_count == c_count_sat) ? r_count : r_count + 16'd1;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_ir      <= '0;
         r_count   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_ir      <= w_ir_nxt;
         r_count   <= w_count_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and next-value logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_ir_nxt      = r_ir;
      w_count_nxt   = r_count;
      w_timeout_nxt = r_timeout;

      case (r_state)
         S_IDLE: begin
            if (bus.Start) begin
               w_pc_nxt      = '0;
               w_count_nxt   = '0;
               w_timeout_nxt = 1'b0;
               w_state_nxt   = S_FETCH;
            end
         end

         // ROM address is presented this cycle; data arrives next cycle
         S_FETCH: begin
            w_state_nxt = S_DECODE;
         end

         // Halt is latched into IR but not retired, so PC and count stay put
         S_DECODE: begin
            w_ir_nxt    = bus.imem_data;
            w_state_nxt = (bus.imem_data == HALT_WORD) ? S_DONE : S_EXEC;
         end

         S_EXEC: begin
            if (w_op == kBRC) begin
               // Offset is zero-extended; wrap-around is intentional
               if (bus.alu_bsign)
                  w_pc_nxt = r_pc - PC_W'(bus.alu_boffset);
               else
                  w_pc_nxt = r_pc + PC_W'(bus.alu_boffset);
            end else begin
               w_pc_nxt = r_pc + PC_W'(1);
            end
            w_count_nxt = w_count_inc;
            if (w_count_inc == c_max_instr) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = S_DONE;
            end else begin
               w_state_nxt   = S_FETCH;
            end
         end

         // No auto-restart: Start must be released before a new run
         S_DONE: begin
            if (!bus.Start)
               w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: decoded from state and IR only
   // ------------------------------------------------------------------
   assign w_we = w_exec && (w_op != kBRC);

   assign bus.imem_addr   = r_pc;
   assign bus.alu_op      = w_op;
   assign bus.alu_t       = r_ir[4];
   assign bus.alu_immi    = r_ir[4:0];
   assign bus.alu_immx    = r_ir[3:0];
   assign bus.rf_raddr    = r_ir[3:0];
   assign bus.rf_we       = w_we;
   // Only load-register and global-store-with-T target rs; all else hits r0
   assign bus.rf_waddr    = (w_we && ((w_op == kLRS) || ((w_op == kGST) && r_ir[4])))
                            ? r_ir[3:0] : 4'h0;
   assign bus.Ack         = (r_state == S_DONE);
   assign bus.instr_count = r_count;
   assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Self-checking bench for alu_seq_ctrl. A registered ROM and a
//                stand-in ALU (branch offset = ImmX, direction = T) surround
//                the sequencer; an instruction-level program interpreter
//                predicts the per-instruction PC, write-back and run result.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq_ctrl;

   localparam int         MAX_INSTR = 16;
   localparam logic [8:0] HALT      = 9'h1FF;
   localparam logic [3:0] K_ACC     = 4'h1;
   localparam logic [3:0] K_ADD     = 4'h2;
   localparam logic [3:0] K_LRS     = 4'h8;
   localparam logic [3:0] K_GST     = 4'h9;
   localparam logic [3:0] K_BRC     = 4'hC;

   logic       clk;
   logic       rst;
   logic [8:0] rom [256];
   int         total = 0;
   int         bad   = 0;

   alu_seq_ctrl_if #(.PC_W(8)) bus ();

   alu_seq_ctrl #(
      .PC_W      (8),
      .MAX_INSTR (MAX_INSTR),
      .HALT_WORD (HALT)
   ) dut (
      .CLK   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered instruction ROM
   always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

   // Stand-in ALU branch unit: offset from ImmX, direction from T
   assign bus.alu_boffset = bus.alu_immx;
   assign bus.alu_bsign   = bus.alu_t;
   assign bus.alu_out     = {3'b000, bus.alu_immi};

   function automatic logic [8:0] mk(input logic [3:0] op, input logic t, input logic [3:0] x);
      return {op, t, x};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = mk(K_ACC, 1'b0, 4'h0);
   endtask

   // Interpret the ROM program, then run the DUT and compare cycle by cycle.
   task automatic run_prog(input string name, input bit glitch);
      logic [7:0] pc;
      logic [7:0] exp_pc [$];
      logic [3:0] exp_wa [$];
      bit         exp_we [$];
      logic [8:0] w;
      logic [3:0] op;
      int         n;
      int         done_cyc;
      int         k;
      bit         to;
      bit         stop;
      pc = 8'd0; n = 0; to = 1'b0; stop = 1'b0;
      while (!stop) begin
         w = rom[pc];
         if (w == HALT) begin
            stop = 1'b1;
         end else begin
            op = w[8:5];
            exp_pc.push_back(pc);
            exp_we.push_back(op != K_BRC);
            exp_wa.push_back(((op == K_LRS) || (op == K_GST && w[4])) ? w[3:0] : 4'h0);
            if (op == K_BRC) pc = w[4] ? pc - 8'(w[3:0]) : pc + 8'(w[3:0]);
            else             pc = pc + 8'd1;
            n++;
            if (n == MAX_INSTR) begin
               to   = 1'b1;
               stop = 1'b1;
            end
         end
      end
      // Halt: FETCH/DECODE of the halt word precede DONE; watchdog: DONE follows EXEC
      done_cyc = to ? 3 * n + 1 : 3 * n + 3;

      @(negedge clk);
      bus.Start = 1'b1;
      for (int c = 1; c <= done_cyc; c++) begin
         @(negedge clk);
         if (c == done_cyc) begin
            total++;
            if (bus.Ack !== 1'b1) begin
               bad++; $display("FAIL %s ack_at_done cyc=%0d got=%b want=1", name, c, bus.Ack);
            end
            total++;
            if (bus.instr_count !== 16'(n)) begin
               bad++; $display("FAIL %s instr_count got=%0d want=%0d", name, bus.instr_count, n);
            end
            total++;
            if (bus.timeout !== to) begin
               bad++; $display("FAIL %s timeout got=%b want=%b", name, bus.timeout, to);
            end
            total++;
            if (bus.imem_addr !== pc) begin
               bad++; $display("FAIL %s final_pc got=%h want=%h", name, bus.imem_addr, pc);
            end
            total++;
            if (bus.rf_we !== 1'b0) begin
               bad++; $display("FAIL %s we_in_done got=%b want=0", name, bus.rf_we);
            end
         end else begin
            total++;
            if (bus.Ack !== 1'b0) begin
               bad++; $display("FAIL %s ack_early cyc=%0d got=%b want=0", name, c, bus.Ack);
            end
            if (c % 3 == 0) begin
               k = c / 3 - 1;
               total++;
               if (bus.imem_addr !== exp_pc[k]) begin
                  bad++; $display("FAIL %s exec_pc i=%0d got=%h want=%h", name, k, bus.imem_addr, exp_pc[k]);
               end
               total++;
               if (bus.alu_op !== rom[exp_pc[k]][8:5]) begin
                  bad++; $display("FAIL %s alu_op i=%0d got=%h want=%h", name, k, bus.alu_op, rom[exp_pc[k]][8:5]);
               end
               total++;
               if (bus.rf_we !== exp_we[k]) begin
                  bad++; $display("FAIL %s rf_we i=%0d got=%b want=%b", name, k, bus.rf_we, exp_we[k]);
               end
               total++;
               if (bus.rf_waddr !== exp_wa[k]) begin
                  bad++; $display("FAIL %s rf_waddr i=%0d got=%h want=%h", name, k, bus.rf_waddr, exp_wa[k]);
               end
            end else begin
               total++;
               if (bus.rf_we !== 1'b0) begin
                  bad++; $display("FAIL %s we_outside_exec cyc=%0d got=%b want=0", name, c, bus.rf_we);
               end
            end
         end
         // Start wiggles mid-run must be ignored
         if (glitch && c < done_cyc) bus.Start = (c != 1);
      end
   endtask

   task automatic end_run(input string name);
      bus.Start = 1'b0;
      @(negedge clk);
      total++;
      if (bus.Ack !== 1'b0) begin
         bad++; $display("FAIL %s ack_release got=%b want=0", name, bus.Ack);
      end
   endtask

   task automatic load_basic();
      clear_rom();
      rom[0] = mk(K_ACC, 1'b0, 4'h5);
      rom[1] = mk(K_ADD, 1'b0, 4'h1);
      rom[2] = HALT;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.Start = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.Ack !== 1'b0)          begin bad++; $display("FAIL reset ack got=%b want=0", bus.Ack); end
      total++; if (bus.imem_addr !== 8'h00)   begin bad++; $display("FAIL reset pc got=%h want=00", bus.imem_addr); end
      total++; if (bus.rf_we !== 1'b0)        begin bad++; $display("FAIL reset rf_we got=%b want=0", bus.rf_we); end
      total++; if (bus.rf_waddr !== 4'h0)     begin bad++; $display("FAIL reset rf_waddr got=%h want=0", bus.rf_waddr); end
      total++; if (bus.instr_count !== 16'h0) begin bad++; $display("FAIL reset count got=%0d want=0", bus.instr_count); end
      total++; if (bus.timeout !== 1'b0)      begin bad++; $display("FAIL reset timeout got=%b want=0", bus.timeout); end
      total++; if (bus.alu_op !== 4'h0)       begin bad++; $display("FAIL reset ir got=%h want=0", bus.alu_op); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      load_basic();
      run_prog("basic", 1'b0);
      end_run("basic");
   endtask

   task automatic test_branch();
      clear_rom();
      rom[6] = mk(K_BRC, 1'b1, 4'h4);       // backward to 2, loops until watchdog
      rom[3] = mk(K_LRS, 1'b0, 4'h7);
      rom[4] = mk(K_GST, 1'b1, 4'h9);
      rom[5] = mk(K_GST, 1'b0, 4'h3);
      run_prog("branch_back", 1'b0);
      end_run("branch_back");
      clear_rom();
      rom[6] = mk(K_BRC, 1'b0, 4'h1);       // not taken -> 7
      rom[7] = HALT;
      run_prog("branch_fwd1", 1'b1);
      end_run("branch_fwd1");
   endtask

   task automatic test_wrap();
      clear_rom();
      rom[1]     = mk(K_BRC, 1'b1, 4'h3);   // 1 - 3 -> FE
      rom[8'hFE] = mk(K_LRS, 1'b1, 4'hA);
      rom[8'hFF] = mk(K_ADD, 1'b0, 4'h2);   // FF + 1 -> 00
      run_prog("wrap", 1'b0);
      end_run("wrap");
   endtask

   task automatic test_spin_watchdog();
      clear_rom();
      rom[0] = mk(K_BRC, 1'b0, 4'h0);
      run_prog("spin", 1'b0);
      end_run("spin");
   endtask

   task automatic test_reset_mid_run();
      load_basic();
      @(negedge clk);
      bus.Start = 1'b1;
      repeat (6) @(negedge clk);             // second EXEC cycle
      total++;
      if (bus.rf_we !== 1'b1) begin
         bad++; $display("FAIL midreset exec_we got=%b want=1", bus.rf_we);
      end
      rst = 1'b1;
      bus.Start = 1'b0;
      @(negedge clk);
      total++; if (bus.Ack !== 1'b0)          begin bad++; $display("FAIL midreset ack got=%b want=0", bus.Ack); end
      total++; if (bus.imem_addr !== 8'h00)   begin bad++; $display("FAIL midreset pc got=%h want=00", bus.imem_addr); end
      total++; if (bus.rf_we !== 1'b0)        begin bad++; $display("FAIL midreset rf_we got=%b want=0", bus.rf_we); end
      total++; if (bus.instr_count !== 16'h0) begin bad++; $display("FAIL midreset count got=%0d want=0", bus.instr_count); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.imem_addr !== 8'h00)   begin bad++; $display("FAIL midreset idle_pc got=%h want=00", bus.imem_addr); end
      total++; if (bus.rf_we !== 1'b0)        begin bad++; $display("FAIL midreset idle_we got=%b want=0", bus.rf_we); end
      run_prog("rerun", 1'b0);
      end_run("rerun");
   endtask

   task automatic test_hold_done();
      load_basic();
      run_prog("hold", 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (bus.Ack !== 1'b1)        begin bad++; $display("FAIL hold ack i=%0d got=%b want=1", i, bus.Ack); end
         total++; if (bus.imem_addr !== 8'h02) begin bad++; $display("FAIL hold pc i=%0d got=%h want=02", i, bus.imem_addr); end
      end
      end_run("hold");
      repeat (2) @(negedge clk);
      total++; if (bus.Ack !== 1'b0)   begin bad++; $display("FAIL hold idle_ack got=%b want=0", bus.Ack); end
      total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL hold idle_we got=%b want=0", bus.rf_we); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(0, 9'h1FE));
         for (int h = 0; h < 3; h++) rom[$urandom_range(0, 255)] = HALT;
         run_prog("random", 1'($urandom_range(0, 1)));
         end_run("random");
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.Start = 1'b0;
      clear_rom();
      test_reset();
      test_basic();
      test_branch();
      test_wrap();
      test_spin_watchdog();
      test_reset_mid_run();
      test_hold_done();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
